// File: rtl/bit_select_pkg.sv
// Shared types for the bit-select path: the scan FSM state encoding.
package bit_select_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

endpackage

// File: rtl/bit_select_chunk.sv
// Combinational slice examiner: counts set bits in one chunk and locates the
// rem-th set bit (LSB first) when the chunk holds enough of them.
module bit_select_chunk #(
    parameter  int CHUNK  = 8,
    parameter  int RANK_W = 6,
    localparam int OFF_W  = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
    input  logic [CHUNK-1:0]  bits,
    input  logic [RANK_W-1:0] rem,
    output logic [RANK_W-1:0] cnt,
    output logic              hit,
    output logic [OFF_W-1:0]  offset
);

    // The running count equals rem exactly once, at the rem-th set bit.
    always_comb begin
        cnt    = '0;
        offset = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (bits[i]) begin
                cnt = cnt + RANK_W'(1);
                if (cnt == rem) begin
                    offset = OFF_W'(i);
                end
            end
        end
        hit = (rem != '0) && (rem <= cnt);
    end

endmodule

// File: rtl/bit_select_iter.sv
// Iterative select: finds the bit index of the k-th set bit of a word by
// scanning one CHUNK-wide slice per cycle while tracking the remaining rank.
module bit_select_iter
    import bit_select_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int CHUNK  = 8,
    localparam int IDX_W  = $clog2(WIDTH),
    localparam int RANK_W = IDX_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [WIDTH-1:0]  data_i,
    input  logic [RANK_W-1:0] rank_i,
    input  logic              data_val_i,
    output logic              data_ready_o,
    output logic [IDX_W-1:0]  index_o,
    output logic              found_o,
    output logic              data_val_o,
    input  logic              data_ready_i
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int PTR_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int OFF_W  = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    state_t             state;
    logic [WIDTH-1:0]   data_q;
    logic [RANK_W-1:0]  rem_q;
    logic [PTR_W-1:0]   ptr_q;

    logic [CHUNK-1:0]   chunk_bits;
    logic [RANK_W-1:0]  chunk_cnt;
    logic               chunk_hit;
    logic [OFF_W-1:0]   chunk_off;
    logic               last_chunk;

    assign chunk_bits   = data_q[int'(ptr_q)*CHUNK +: CHUNK];
    assign last_chunk   = (ptr_q == PTR_W'(NCHUNK - 1));
    assign data_ready_o = (state == IDLE);

    bit_select_chunk #(
        .CHUNK  (CHUNK),
        .RANK_W (RANK_W)
    ) u_chunk (
        .bits   (chunk_bits),
        .rem    (rem_q),
        .cnt    (chunk_cnt),
        .hit    (chunk_hit),
        .offset (chunk_off)
    );

    // A zero rank resolves on the first scan cycle, giving the same one-cycle
    // latency as a hit in chunk 0. Subtraction only happens on a miss, where
    // rem is known to exceed the chunk count, so rem cannot underflow.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            data_q     <= '0;
            rem_q      <= '0;
            ptr_q      <= '0;
            index_o    <= '0;
            found_o    <= 1'b0;
            data_val_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_val_i) begin
                        data_q <= data_i;
                        rem_q  <= rank_i;
                        ptr_q  <= '0;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (rem_q == '0) begin
                        index_o    <= '0;
                        found_o    <= 1'b0;
                        data_val_o <= 1'b1;
                        state      <= DONE;
                    end else if (chunk_hit) begin
                        index_o    <= IDX_W'(int'(ptr_q)*CHUNK + int'(chunk_off));
                        found_o    <= 1'b1;
                        data_val_o <= 1'b1;
                        state      <= DONE;
                    end else if (last_chunk) begin
                        index_o    <= '0;
                        found_o    <= 1'b0;
                        data_val_o <= 1'b1;
                        state      <= DONE;
                    end else begin
                        rem_q <= rem_q - chunk_cnt;
                        ptr_q <= ptr_q + PTR_W'(1);
                    end
                end
                DONE: begin
                    if (data_ready_i) begin
                        data_val_o <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
